// File: rtl/bf16_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined bfloat16 multiplier between NREQ requesters.
// A {valid, id} tag pipeline follows each operand pair so its product goes back to the requester that issued it.
module bf16_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 1,
    parameter int IDW     = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [16*NREQ-1:0]             req_a,
    input  logic [16*NREQ-1:0]             req_b,
    output logic [15:0]                    mul_a,
    output logic [15:0]                    mul_b,
    input  logic [15:0]                    mul_c,
    output logic [NREQ-1:0]                resp_valid,
    output logic [15:0]                    resp_c,
    output logic [IDW-1:0]                 resp_id,
    output logic [$clog2(MUL_LAT+2)-1:0]   in_flight
);

    localparam int CW = $clog2(MUL_LAT+2);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] grant_id;
    logic           grant_found;
    logic           issue;
    logic           resp_fire;
    logic [IDW:0]   scan_idx;

    logic [MUL_LAT:0] tag_v;
    logic [IDW-1:0]   tag_id [MUL_LAT+1];

    // Search upward from ptr with wrap; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, ptr} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NREQ))
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        issue     = grant_found & ~flush;
        req_ready = issue ? (ONE << grant_id) : '0;
        ptr_next  = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
        resp_fire = tag_v[MUL_LAT] & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            tag_v     <= '0;
            for (int s = 0; s <= MUL_LAT; s++)
                tag_id[s] <= '0;
            in_flight <= '0;
        end else begin
            if (issue) begin
                mul_a <= req_a[16*grant_id +: 16];
                mul_b <= req_b[16*grant_id +: 16];
                ptr   <= ptr_next;
            end else begin
                mul_a <= '0;
                mul_b <= '0;
            end
            if (flush)
                tag_v <= '0;
            else
                tag_v <= {tag_v[MUL_LAT-1:0], issue};
            tag_id[0] <= grant_id;
            for (int s = 1; s <= MUL_LAT; s++)
                tag_id[s] <= tag_id[s-1];
            if (flush)
                in_flight <= '0;
            else
                in_flight <= in_flight + CW'(issue) - CW'(resp_fire);
        end
    end

    // The final tag stage lines up with mul_c; a flush edge also swallows that product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= '0;
            resp_c     <= '0;
            resp_id    <= '0;
        end else if (resp_fire) begin
            resp_valid <= ONE << tag_id[MUL_LAT];
            resp_c     <= mul_c;
            resp_id    <= tag_id[MUL_LAT];
        end else begin
            resp_valid <= '0;
        end
    end

endmodule

// File: doc/bf16_mul_arbiter.md
Name: bf16_mul_arbiter

Overview:
- Round-robin arbiter that shares one pipelined bfloat16 multiplier (`mul`: a, b -> c, clocked) between NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and registers them into the multiplier.
- Tracks in-flight operations with a tag pipeline and routes each product back to its originating requester.
- Sits between the MAC lanes and the single shared `mul` instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 1, cycles from mul_a/mul_b presented to mul_c valid (≥1; must match the `mul` instance).
- IDW, 2, requester id width, ≥ clog2(NREQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; drops all in-flight operations.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester grant/accept, at most one bit high.
- req_a  input  16*NREQ  operand A, requester i at [16i+15:16i].
- req_b  input  16*NREQ  operand B, same packing.
- mul_a  output  16  operand A to shared multiplier (registered).
- mul_b  output  16  operand B to shared multiplier (registered).
- mul_c  input  16  product from shared multiplier.
- resp_valid  output  NREQ  one-hot product-valid strobe, single cycle.
- resp_c  output  16  product, shared by all requesters, qualified by resp_valid.
- resp_id  output  IDW  id of the requester receiving the current response.
- in_flight  output  clog2(MUL_LAT+2)  count of issued, not-yet-returned operations.

Behaviour:
- Reset (rst_n=0, async):
  - mul_a=mul_b=0, resp_valid=0, resp_c=0, resp_id=0, in_flight=0.
  - Tag pipeline cleared; RR pointer=0, so requester 0 has highest priority.
- Arbitration (combinational each cycle):
  - Among asserted req_valid, grant the first index at or after ptr, searching upward with wrap NREQ-1 -> 0.
  - req_ready[g]=1 only for that index; all 0 when no req_valid or flush=1.
  - req_ready never depends on req_a/req_b.
- Handshake: req_valid[i]&req_ready[i] at a rising edge is an issue.
- On an issue edge:
  - mul_a<=req_a[i], mul_b<=req_b[i].
  - Tag stage 0 <= {1,i}.
  - ptr <= (i+1) mod NREQ.
- Non-issue edge: mul_a/mul_b <= 0 (bubble), tag stage 0 valid <= 0, ptr unchanged.
- Tag pipeline:
  - MUL_LAT+1 stages of {valid, id}, shifted every cycle.
  - The final stage aligns with mul_c for the matching operands.
- Response, when the final tag stage is valid:
  - resp_valid[id]=1, resp_c=mul_c, resp_id=id, registered or aligned so that an issue at edge T yields resp_valid during cycle T+1+MUL_LAT.
  - Otherwise resp_valid=0; resp_c and resp_id hold their last value.
- No response backpressure: requesters must accept every product. Throughput is one issue per cycle.
- Ordering: responses return in issue order. One requester may have several operations in flight.
- in_flight: +1 on issue, -1 on response, unchanged when both occur in the same cycle. Never exceeds MUL_LAT+1.
- flush=1 at an edge:
  - All tag valids cleared; no issue that cycle.
  - mul_a/mul_b <= 0; in_flight <= 0; ptr unchanged.
  - Products already in `mul` produce no response.
- Reset mid-operation: same effect as flush plus ptr <= 0, applied asynchronously.
- Single requester continuously valid: granted every cycle (back-to-back issues).
- Fairness: with all NREQ requesters continuously valid, the grant sequence is 0,1,...,NREQ-1,0,...

Test Plan:
- After reset, req_valid=0001, req_a[0]=3F80, req_b[0]=3F80 for one cycle -> req_ready=0001 that cycle; resp_valid=0001, resp_c=3F80, resp_id=0 exactly 1+MUL_LAT cycles later; in_flight 0->1->0.
- req_valid=0101 continuously, operands 3FC0*4000 (req0) and C000*3FC0 (req2) -> grants alternate 0,2,0,2; responses alternate 4040 (id0) and C040 (id2) in issue order; one issue per cycle.
- req_valid=1111 continuously, each requester with 3F00*3F80 -> grant order 0,1,2,3,0; every resp_c=3F00; no requester starved.
- Idle cycles between issues -> mul_a=mul_b=0000 during bubbles; resp_valid=0 aligned to those bubbles.
- Issue on req1 (0000*3F80), assert flush the next cycle -> no resp_valid for that operation; in_flight=0; the next issue returns normally with correct latency.
- Deassert rst_n with two operations in flight and ptr=3 -> all outputs 0 immediately; after release, req_valid=1111 grants requester 0 first.
